hilo_unit: RTL and testbench

- HI/LO special-register unit on the receiving end of the ALU's HiLoEn/HiLoWrite/HiLoRead interface.
- Holds HI/LO and accepts 64-bit multiply-accumulate writes and MTHI/MTLO writes.
- Supplies HiLoRead for MADD/MSUB and MFHI/MFLO.
- Adds an iterative 32-cycle DIV/DIVU engine whose Busy output stalls the pipeline.

---
 rtl/hilo_pkg.sv | 33 +++
 rtl/div_core.sv | 66 ++++++
 rtl/hilo_unit.sv | 164 ++++++++++++++++
 tb/tb_hilo_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO special-register unit.
//   state_t        : control FSM states (IDLE, DIV, FIX)
//   DATA_W         : width of HI, LO and divide operands
//   DIV_CYCLES     : quotient iterations, one bit per cycle
//   DIV_BY_ZERO_LO : LO value forced when the divisor is zero
package hilo_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned DIV_CYCLES = 32;
    localparam int unsigned CNT_W      = $clog2(DIV_CYCLES);

    localparam logic [DATA_W-1:0] DIV_BY_ZERO_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Magnitude of x when treated as signed (s=1); raw value otherwise.
    // The most negative value maps to itself, which is the correct
    // unsigned magnitude.
    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x,
                                                  input logic              s);
        return (s && x[DATA_W-1]) ? ((~x) + DATA_W'(1)) : x;
    endfunction

    // Two's-complement negation.
    function automatic logic [DATA_W-1:0] neg_val(input logic [DATA_W-1:0] x);
        return (~x) + DATA_W'(1);
    endfunction

endpackage

// File: rtl/div_core.sv
// Restoring unsigned divide datapath, one quotient bit per step.
//   Clk, Rst_n    : clock, async active-low reset
//   i_load        : capture operands, clear remainder, reload counter
//   i_step        : perform one restoring iteration
//   i_dividend    : unsigned dividend (captured on i_load)
//   i_divisor     : unsigned divisor (captured on i_load)
//   o_quotient    : quotient register (valid after DIV_CYCLES steps)
//   o_remainder   : remainder register (valid after DIV_CYCLES steps)
//   o_last_c      : counter is at zero; current step is the final one
module div_core
    import hilo_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [DATA_W-1:0] i_dividend,
    input  logic [DATA_W-1:0] i_divisor,
    output logic [DATA_W-1:0] o_quotient,
    output logic [DATA_W-1:0] o_remainder,
    output logic              o_last_c
);

    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_quo;   // dividend bits shift out of the top, quotient bits in at the bottom
    logic [DATA_W-1:0] r_div;
    logic [CNT_W-1:0]  r_cnt;

    logic [DATA_W:0]   w_trial;
    logic              w_ge;
    logic [DATA_W-1:0] w_diff;

    // Trial remainder with the next dividend bit shifted in.
    always_comb begin
        w_trial = {r_rem, r_quo[DATA_W-1]};
        w_ge    = (w_trial >= {1'b0, r_div});
        // When w_ge holds the difference fits in DATA_W bits.
        w_diff  = w_trial[DATA_W-1:0] - r_div;
    end

    // Iteration registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_rem <= '0;
            r_quo <= '0;
            r_div <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_rem <= '0;
            r_quo <= i_dividend;
            r_div <= i_divisor;
            r_cnt <= CNT_W'(DIV_CYCLES - 1);
        end else if (i_step) begin
            r_rem <= w_ge ? w_diff : w_trial[DATA_W-1:0];
            r_quo <= {r_quo[DATA_W-2:0], w_ge};
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;
    assign o_last_c    = (r_cnt == '0);

endmodule

// File: rtl/hilo_unit.sv
// HI/LO special-register unit with an iterative DIV/DIVU engine.
//   Clk, Rst_n        : clock, async active-low reset
//   HiLoEn/HiLoWrite  : 64-bit {HI,LO} write from the ALU
//   MthiEn/MtloEn     : MTHI/MTLO write strobes, data on MtData
//   DivStart          : start a divide; DivSigned/DivA/DivB sampled with it
//   HiLoRead          : {HI,LO}, combinational from the registers
//   Busy              : divide in progress (pipeline stall)
//   DivDone           : one-cycle pulse after the result is written
//   DivByZero         : one-cycle pulse with DivDone for a zero divisor
module hilo_unit
    import hilo_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        HiLoEn,
    input  logic [63:0] HiLoWrite,
    input  logic        MthiEn,
    input  logic        MtloEn,
    input  logic [31:0] MtData,
    input  logic        DivStart,
    input  logic        DivSigned,
    input  logic [31:0] DivA,
    input  logic [31:0] DivB,
    output logic [63:0] HiLoRead,
    output logic        Busy,
    output logic        DivDone,
    output logic        DivByZero
);

    state_t            r_state;
    state_t            w_state_n;

    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic [DATA_W-1:0] w_hi_n;
    logic [DATA_W-1:0] w_lo_n;

    logic              r_busy;
    logic              r_div_done;
    logic              r_div_by_zero;

    // Per-divide context captured at start.
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_b_zero;
    logic [DATA_W-1:0] r_a_raw;

    logic              w_load;
    logic              w_step;
    logic              w_fix;
    logic              w_last;
    logic [DATA_W-1:0] w_quo;
    logic [DATA_W-1:0] w_rem;

    div_core u_div_core (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .i_load      (w_load),
        .i_step      (w_step),
        .i_dividend  (abs_val(DivA, DivSigned)),
        .i_divisor   (abs_val(DivB, DivSigned)),
        .o_quotient  (w_quo),
        .o_remainder (w_rem),
        .o_last_c    (w_last)
    );

    // State register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Next state, datapath controls and HI/LO next values.
    always_comb begin
        w_state_n = r_state;
        w_load    = 1'b0;
        w_step    = 1'b0;
        w_fix     = 1'b0;
        w_hi_n    = r_hi;
        w_lo_n    = r_lo;

        case (r_state)
            IDLE: begin
                // DivStart wins; any same-cycle register write is dropped.
                if (DivStart) begin
                    w_load    = 1'b1;
                    w_state_n = DIV;
                end else if (HiLoEn) begin
                    w_hi_n = HiLoWrite[63:32];
                    w_lo_n = HiLoWrite[31:0];
                end else begin
                    if (MthiEn) w_hi_n = MtData;
                    if (MtloEn) w_lo_n = MtData;
                end
            end
            DIV: begin
                w_step = 1'b1;
                if (w_last) w_state_n = FIX;
            end
            FIX: begin
                w_fix     = 1'b1;
                w_state_n = IDLE;
                if (r_b_zero) begin
                    w_hi_n = r_a_raw;
                    w_lo_n = DIV_BY_ZERO_LO;
                end else begin
                    w_hi_n = r_neg_r ? neg_val(w_rem) : w_rem;
                    w_lo_n = r_neg_q ? neg_val(w_quo) : w_quo;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    // HI/LO registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            r_hi <= w_hi_n;
            r_lo <= w_lo_n;
        end
    end

    // Sign and zero-divisor context for the result fix-up.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_b_zero <= 1'b0;
            r_a_raw  <= '0;
        end else if (w_load) begin
            r_neg_q  <= DivSigned & (DivA[DATA_W-1] ^ DivB[DATA_W-1]);
            r_neg_r  <= DivSigned & DivA[DATA_W-1];
            r_b_zero <= (DivB == '0);
            r_a_raw  <= DivA;
        end
    end

    // Status outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_busy        <= 1'b0;
            r_div_done    <= 1'b0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_busy        <= (w_state_n != IDLE);
            r_div_done    <= w_fix;
            r_div_by_zero <= w_fix & r_b_zero;
        end
    end

    assign HiLoRead  = {r_hi, r_lo};
    assign Busy      = r_busy;
    assign DivDone   = r_div_done;
    assign DivByZero = r_div_by_zero;

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: directed and randomized register
// writes and divides against an arithmetic reference model.
module tb_hilo_unit;

    logic        Clk;
    logic        Rst_n;
    logic        HiLoEn;
    logic [63:0] HiLoWrite;
    logic        MthiEn;
    logic        MtloEn;
    logic [31:0] MtData;
    logic        DivStart;
    logic        DivSigned;
    logic [31:0] DivA;
    logic [31:0] DivB;
    logic [63:0] HiLoRead;
    logic        Busy;
    logic        DivDone;
    logic        DivByZero;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    hilo_unit dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .HiLoEn    (HiLoEn),
        .HiLoWrite (HiLoWrite),
        .MthiEn    (MthiEn),
        .MtloEn    (MtloEn),
        .MtData    (MtData),
        .DivStart  (DivStart),
        .DivSigned (DivSigned),
        .DivA      (DivA),
        .DivB      (DivB),
        .HiLoRead  (HiLoRead),
        .Busy      (Busy),
        .DivDone   (DivDone),
        .DivByZero (DivByZero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        HiLoEn    = 1'b0;
        HiLoWrite = '0;
        MthiEn    = 1'b0;
        MtloEn    = 1'b0;
        MtData    = '0;
        DivStart  = 1'b0;
        DivSigned = 1'b0;
        DivA      = '0;
        DivB      = '0;
    endtask

    // Reference divide: {HI,LO} = {remainder, quotient}, truncating toward zero.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // One IDLE-cycle register write, checked against the model.
    task automatic do_write(input string tag, input logic en, input logic [63:0] w,
                            input logic mth, input logic mtl, input logic [31:0] d);
        HiLoEn = en; HiLoWrite = w; MthiEn = mth; MtloEn = mtl; MtData = d;
        if (en) begin
            m_hi = w[63:32];
            m_lo = w[31:0];
        end else begin
            if (mth) m_hi = d;
            if (mtl) m_lo = d;
        end
        tick();
        clear_inputs();
        chk(tag, HiLoRead, {m_hi, m_lo});
    endtask

    // Full divide with optional junk writes/starts while busy.
    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic noise);
        logic [63:0] pre;
        logic [63:0] exp;
        logic        ok_busy;
        logic        ok_hold;
        logic        ok_done;
        pre = {m_hi, m_lo};
        exp = ref_div(a, b, s);
        DivStart = 1'b1; DivSigned = s; DivA = a; DivB = b;
        tick();
        clear_inputs();
        chk({tag, "_busy_e0"}, 64'(Busy), 64'd1);
        ok_busy = 1'b1; ok_hold = 1'b1; ok_done = 1'b1;
        for (int i = 1; i <= 33; i++) begin
            if (noise) begin
                HiLoEn    = 1'($urandom_range(0, 1));
                HiLoWrite = {32'($urandom), 32'($urandom)};
                MthiEn    = 1'($urandom_range(0, 1));
                MtloEn    = 1'($urandom_range(0, 1));
                MtData    = 32'($urandom);
                DivStart  = 1'($urandom_range(0, 1));
                DivSigned = 1'($urandom_range(0, 1));
                DivA      = 32'($urandom);
                DivB      = 32'($urandom);
            end
            tick();
            clear_inputs();
            if (i < 33) begin
                if (Busy !== 1'b1) ok_busy = 1'b0;
                if (HiLoRead !== pre) ok_hold = 1'b0;
                if (DivDone !== 1'b0) ok_done = 1'b0;
            end
        end
        chk({tag, "_busy_held"}, 64'(ok_busy), 64'd1);
        chk({tag, "_hilo_held"}, 64'(ok_hold), 64'd1);
        chk({tag, "_no_early_done"}, 64'(ok_done), 64'd1);
        chk({tag, "_busy_end"}, 64'(Busy), 64'd0);
        chk({tag, "_result"}, HiLoRead, exp);
        chk({tag, "_done"}, 64'(DivDone), 64'd1);
        chk({tag, "_dbz"}, 64'(DivByZero), 64'(b == 32'd0));
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        tick();
        chk({tag, "_done_pulse"}, {62'd0, DivDone, DivByZero}, 64'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic        seen_done;

        clear_inputs();
        Rst_n = 1'b1;
        m_hi  = '0;
        m_lo  = '0;
        #2;
        Rst_n = 1'b0;

        // Write attempted while in reset must not land.
        HiLoEn    = 1'b1;
        HiLoWrite = 64'h0000_0001_FFFF_FFFE;
        repeat (2) tick();
        chk("reset_hilo", HiLoRead, 64'd0);
        chk("reset_status", {61'd0, Busy, DivDone, DivByZero}, 64'd0);
        Rst_n = 1'b1;
        do_write("first_write", 1'b1, 64'h0000_0001_FFFF_FFFE, 1'b0, 1'b0, 32'd0);

        do_write("mt_both", 1'b0, 64'd0, 1'b1, 1'b1, 32'hA5A5_A5A5);
        do_write("hilo_over_mthi", 1'b1, 64'h1122_3344_5566_7788, 1'b1, 1'b0, 32'hDEAD_BEEF);
        do_write("mtlo_only", 1'b0, 64'd0, 1'b0, 1'b1, 32'h0BAD_F00D);

        for (int i = 0; i < 20; i++) begin
            do_write("rand_write", 1'($urandom_range(0, 1)),
                     {32'($urandom), 32'($urandom)},
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     32'($urandom));
        end

        do_div("divu_100_7", 32'd100, 32'd7, 1'b0, 1'b1);
        do_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        do_div("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        do_div("div_zero", 32'h1234_5678, 32'd0, 1'b1, 1'b0);
        do_div("divu_big", 32'hFFFF_FFFF, 32'h0000_0003, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            ra = 32'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                default: rb = 32'($urandom);
            endcase
            rs = 1'($urandom_range(0, 1));
            do_div("rand_div", ra, rb, rs, 1'b1);
            do_write("after_div", 1'b0, 64'd0, 1'($urandom_range(0, 1)), 1'b0, 32'($urandom));
        end

        // Reset during a divide aborts it.
        DivStart = 1'b1; DivSigned = 1'b0; DivA = 32'd1000; DivB = 32'd3;
        tick();
        clear_inputs();
        repeat (10) tick();
        #2;
        Rst_n = 1'b0;
        #1;
        m_hi = '0;
        m_lo = '0;
        chk("abort_busy", 64'(Busy), 64'd0);
        chk("abort_hilo", HiLoRead, 64'd0);
        repeat (2) tick();
        Rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (DivDone !== 1'b0 || Busy !== 1'b0) seen_done = 1'b1;
        end
        chk("abort_quiet", 64'(seen_done), 64'd0);
        chk("abort_hilo_after", HiLoRead, 64'd0);
        do_div("post_abort", 32'd1000, 32'd3, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
